// File: rtl/serial_addsub_unit.sv
// Multi-cycle N-bit adder/subtractor: CHUNK bits per clock, LSB first, registered carry chain.
// Results and flags update together on entry to DONE and hold until the next op completes.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold the last result
//   RUN   | one chunk per cycle into the shadow sum, busy=1
//   DONE  | one cycle, done=1; start here chains the next op
module serial_addsub_unit #(
  parameter int N     = 8,
  parameter int CHUNK = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         cin,
  input  logic         select,
  output logic [N-1:0] S,
  output logic         cout,
  output logic         overflow,
  output logic         zero,
  output logic         busy,
  output logic         done
);
  localparam int BEATS = N / CHUNK;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW    = $clog2(N);

  if (N < 2 || CHUNK < 1 || CHUNK > N || (N % CHUNK) != 0) begin : g_param_check
    $error("serial_addsub_unit: illegal N/CHUNK combination");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_n;
  logic [BW-1:0]  beat;
  logic [IW-1:0]  idx;
  logic [N-1:0]   a_q, b_q, shadow, s_full;
  logic           sel_q, carry;
  logic [CHUNK-1:0] a_k, b_k;
  logic [CHUNK:0] sum;
  logic           last, accept;

  assign last   = (beat == BW'(BEATS - 1));
  assign accept = start && (state != RUN);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Subtraction is A + ~B + ~borrow_in, so the chain carry is the inverted borrow.
  always_comb begin
    idx    = IW'(int'(beat) * CHUNK);
    a_k    = a_q[idx +: CHUNK];
    b_k    = b_q[idx +: CHUNK] ^ {CHUNK{sel_q}};
    sum    = {1'b0, a_k} + {1'b0, b_k} + {{CHUNK{1'b0}}, carry};
    s_full = shadow;
    s_full[idx +: CHUNK] = sum[CHUNK-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= 1'b0;
      carry    <= 1'b0;
      beat     <= '0;
      shadow   <= '0;
      S        <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (accept) begin
      a_q   <= A;
      b_q   <= B;
      sel_q <= select;
      carry <= select ? ~cin : cin;
      beat  <= '0;
    end else if (state == RUN) begin
      shadow <= s_full;
      carry  <= sum[CHUNK];
      beat   <= beat + 1'b1;
      if (last) begin
        S        <= s_full;
        cout     <= sel_q ^ sum[CHUNK];
        overflow <= (a_q[N-1] ~^ (b_q[N-1] ^ sel_q)) & (s_full[N-1] ^ a_q[N-1]);
        zero     <= ~|s_full;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Directed and table-driven checks of serial_addsub_unit (N=8/CHUNK=2),
// plus N=16 with CHUNK=16 and CHUNK=1 against an arithmetic golden model.
module tb_serial_addsub_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, cin, sel;
  logic [7:0] a, b, s;
  logic       cout, ov, zero, busy, done;

  logic        start16, cin16, sel16;
  logic [15:0] a16, b16, s_w, s_n;
  logic        cout_w, ov_w, zero_w, busy_w, done_w;
  logic        cout_n, ov_n, zero_n, busy_n, done_n;

  int total = 0;
  int bad   = 0;

  serial_addsub_unit #(.N(8), .CHUNK(2)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .cin(cin), .select(sel),
    .S(s), .cout(cout), .overflow(ov), .zero(zero), .busy(busy), .done(done));

  serial_addsub_unit #(.N(16), .CHUNK(16)) dut_wide (
    .clk(clk), .rst(rst), .start(start16), .A(a16), .B(b16), .cin(cin16), .select(sel16),
    .S(s_w), .cout(cout_w), .overflow(ov_w), .zero(zero_w), .busy(busy_w), .done(done_w));

  serial_addsub_unit #(.N(16), .CHUNK(1)) dut_narrow (
    .clk(clk), .rst(rst), .start(start16), .A(a16), .B(b16), .cin(cin16), .select(sel16),
    .S(s_n), .cout(cout_n), .overflow(ov_n), .zero(zero_n), .busy(busy_n), .done(done_n));

  typedef struct {
    logic [7:0] a, b;
    logic       cin, sel;
    logic [7:0] s;
    logic       cout, ov, zero;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      total++;
      if ((done && busy) || (done_w && busy_w) || (done_n && busy_n)) begin
        bad++;
        $display("FAIL done_busy_overlap: done and busy both 1 at %0t", $time);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Returns cycles from the accepting edge to the first cycle with done=1.
  task automatic op8(input logic [7:0] ia, ib, input logic ic, is, output int lat, output int nbusy);
    @(negedge clk);
    a = ia; b = ib; cin = ic; sel = is; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1; nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op16(input logic [15:0] ia, ib, input logic ic, is);
    logic [15:0] es;
    logic        ec, eov, ez;
    longint      sr;
    int          lat, lw, ln;
    if (is) begin
      es = ia - ib - 16'(ic);
      ec = ({1'b0, ia} < ({1'b0, ib} + 17'(ic)));
      sr = longint'($signed(ia)) - longint'($signed(ib)) - longint'(ic);
    end else begin
      es = ia + ib + 16'(ic);
      ec = (({1'b0, ia} + {1'b0, ib} + 17'(ic)) >> 16) != 17'd0;
      sr = longint'($signed(ia)) + longint'($signed(ib)) + longint'(ic);
    end
    eov = (sr > 32767) || (sr < -32768);
    ez  = (es == 16'h0);
    @(negedge clk);
    a16 = ia; b16 = ib; cin16 = ic; sel16 = is; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0; lat = 1; lw = 0; ln = 0;
    while ((lw == 0 || ln == 0) && lat < 60) begin
      if (done_w && lw == 0) lw = lat;
      if (done_n && ln == 0) ln = lat;
      @(negedge clk);
      lat++;
    end
    chk("w16 latency", lw, 2);
    chk("n16 latency", ln, 17);
    chk("w16 S", s_w, es);
    chk("n16 S", s_n, es);
    chk("w16 cout", cout_w, ec);
    chk("n16 cout", cout_n, ec);
    chk("w16 overflow", ov_w, eov);
    chk("n16 overflow", ov_n, eov);
    chk("w16 zero", zero_w, ez);
    chk("n16 zero", zero_n, ez);
  endtask

  initial begin
    int lat, nb, saw;
    vecs[0] = '{8'h3C, 8'h25, 1'b0, 1'b0, 8'h61, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h21, 8'h20, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[9] = '{8'h55, 8'hAA, 1'b0, 1'b1, 8'hAB, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sel = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sel16 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset S", s, 8'h00);
    chk("reset cout", cout, 1'b0);
    chk("reset overflow", ov, 1'b0);
    chk("reset zero", zero, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sel, lat, nb);
      chk($sformatf("v%0d latency", i), lat, 5);
      chk($sformatf("v%0d busy cycles", i), nb, 4);
      chk($sformatf("v%0d S", i), s, vecs[i].s);
      chk($sformatf("v%0d cout", i), cout, vecs[i].cout);
      chk($sformatf("v%0d overflow", i), ov, vecs[i].ov);
      chk($sformatf("v%0d zero", i), zero, vecs[i].zero);
      @(negedge clk);
      chk($sformatf("v%0d done pulse width", i), done, 1'b0);
      chk($sformatf("v%0d S hold", i), s, vecs[i].s);
    end

    // Mid-RUN start pulse and operand changes are ignored; start in DONE chains the next op.
    @(negedge clk);
    a = 8'h3C; b = 8'h25; cin = 1'b0; sel = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'hFF; b = 8'hFF; cin = 1'b1; sel = 1'b1; lat = 1;
    @(negedge clk);
    start = 1'b1; lat++;
    @(negedge clk);
    start = 1'b0; lat++;
    chk("S held during run", s, 8'hAB);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("hs latency", lat, 5);
    chk("hs S", s, 8'h61);
    chk("hs cout", cout, 1'b0);
    a = 8'h10; b = 8'h20; cin = 1'b0; sel = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1;
    chk("b2b busy", busy, 1'b1);
    chk("b2b S holds old", s, 8'h61);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b latency", lat, 5);
    chk("b2b S", s, 8'hF0);
    chk("b2b cout", cout, 1'b1);
    repeat (3) @(negedge clk);
    chk("idle S hold", s, 8'hF0);

    // Reset during beat 2 aborts the op with no done pulse.
    a = 8'h3C; b = 8'h25; cin = 1'b0; sel = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort S", s, 8'h00);
    chk("abort cout", cout, 1'b0);
    chk("abort overflow", ov, 1'b0);
    chk("abort zero", zero, 1'b0);
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    saw = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) saw++;
    end
    chk("abort no activity", saw, 0);
    op8(8'h3C, 8'h25, 1'b0, 1'b0, lat, nb);
    chk("post-abort latency", lat, 5);
    chk("post-abort busy cycles", nb, 4);
    chk("post-abort S", s, 8'h61);
    chk("post-abort zero", zero, 1'b0);

    op16(16'hFFFF, 16'h0001, 1'b1, 1'b0);
    op16(16'h8000, 16'h0001, 1'b0, 1'b1);
    op16(16'h1234, 16'h1234, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      op16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
